// File: rtl/shift_defs.sv
// rtl/shift_defs.sv - shared op codes, state encodings and constants for the shift sequencer
package shift_defs;

    localparam logic [2:0] SH_SLL     = 3'b000;
    localparam logic [2:0] SH_SRL     = 3'b001;
    localparam logic [2:0] SH_SRA     = 3'b010;
    localparam logic [2:0] SH_SLLV    = 3'b011;
    localparam logic [2:0] SH_SRLV    = 3'b100;
    localparam logic [2:0] SH_SRAV    = 3'b101;
    localparam logic [2:0] SH_LUI     = 3'b110;
    localparam logic [2:0] SH_ILLEGAL = 3'b111;

    localparam logic [4:0] LUI_AMOUNT = 5'd16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/response bus between control unit and shift sequencer
interface shift_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [15:0]      offset;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, offset, a, b,
        input  busy, done, err, result
    );

    modport slave (
        input  start, op, offset, a, b,
        output busy, done, err, result
    );
endinterface

// File: rtl/shift_amount_sel.sv
// rtl/shift_amount_sel.sv - picks the shift amount source for each op and flags illegal ops
module shift_amount_sel
    import shift_defs::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [2:0]         op,
    input  logic [15:0]        offset,
    input  logic [WIDTH-1:0]   b,
    output logic [SHAMT_W-1:0] amount,
    output logic               illegal
);

    // Only the shamt field and the low bits of rs matter here.
    logic unused_bits;
    assign unused_bits = ^{offset[15:11], offset[5:0], b[WIDTH-1:SHAMT_W]};

    // Amount source: shamt field, rs low bits, or the fixed lui distance.
    always_comb begin
        amount  = '0;
        illegal = 1'b0;
        case (op)
            SH_SLL, SH_SRL, SH_SRA:    amount = offset[6 +: SHAMT_W];
            SH_SLLV, SH_SRLV, SH_SRAV: amount = b[SHAMT_W-1:0];
            SH_LUI:                    amount = SHAMT_W'(LUI_AMOUNT);
            default:                   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multicycle one-bit-per-clock shifter for MIPS shift-class ops
module shift_sequencer
    import shift_defs::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    shift_sequencer_if.slave  bus
);

    state_t             state;
    logic [2:0]         op_reg;
    logic [WIDTH-1:0]   work_reg;
    logic [SHAMT_W-1:0] cnt_reg;
    logic               busy_r;
    logic               done_r;
    logic               err_r;
    logic [WIDTH-1:0]   result_r;

    logic [SHAMT_W-1:0] amount;
    logic               illegal;
    logic [WIDTH-1:0]   load_data;
    logic [WIDTH-1:0]   shifted;

    shift_amount_sel #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_amount_sel (
        .op      (bus.op),
        .offset  (bus.offset),
        .b       (bus.b),
        .amount  (amount),
        .illegal (illegal)
    );

    // lui shifts the immediate itself; everything else shifts rt.
    assign load_data = (bus.op == SH_LUI) ? {{(WIDTH-16){1'b0}}, bus.offset} : bus.a;

    // One-bit step of work_reg in the direction implied by the latched op.
    always_comb begin
        shifted = work_reg;
        case (op_reg)
            SH_SLL, SH_SLLV, SH_LUI: shifted = {work_reg[WIDTH-2:0], 1'b0};
            SH_SRA, SH_SRAV:         shifted = {work_reg[WIDTH-1], work_reg[WIDTH-1:1]};
            default:                 shifted = {1'b0, work_reg[WIDTH-1:1]};
        endcase
    end

    // Control FSM with counter, work register and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            op_reg   <= SH_SLL;
            work_reg <= '0;
            cnt_reg  <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            result_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                    if (bus.start) begin
                        op_reg   <= bus.op;
                        work_reg <= load_data;
                        cnt_reg  <= amount;
                        busy_r   <= 1'b1;
                        // Zero-distance and illegal requests skip SHIFT so cnt_reg never underflows.
                        if (amount == '0 || illegal) begin
                            state    <= S_DONE;
                            done_r   <= 1'b1;
                            err_r    <= illegal;
                            result_r <= load_data;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    work_reg <= shifted;
                    cnt_reg  <= cnt_reg - SHAMT_W'(1);
                    if (cnt_reg == SHAMT_W'(1)) begin
                        state    <= S_DONE;
                        done_r   <= 1'b1;
                        result_r <= shifted;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.err    = err_r;
    assign bus.result = result_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for the shift sequencer
module tb_shift_sequencer;
    import shift_defs::*;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          lat;
        int          start_cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;
    exp_t q[$];

    shift_sequencer_if #(.WIDTH(32)) bus ();

    shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset !== 1'b1 && bus.done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending request");
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "_result"}, bus.result, e.res);
                check({e.name, "_err"}, {31'b0, bus.err}, {31'b0, e.err});
                check({e.name, "_latency"}, cyc - e.start_cyc + 1, e.lat);
                check({e.name, "_pulse"}, {31'b0, prev_done}, 32'd0);
            end
        end
        prev_done = (bus.done === 1'b1);
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.busy !== 1'b0 || bus.done !== 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] offset, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic exp_err,
                         input int lat, input string name, input bit push);
        wait_idle();
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.offset = offset;
        bus.a      = a;
        bus.b      = b;
        if (push) q.push_back('{exp_res, exp_err, lat, cyc + 1, name});
        @(negedge clk);
        bus.start  = 1'b0;
        bus.op     = 3'($urandom);
        bus.offset = 16'($urandom);
        bus.a      = $urandom;
        bus.b      = $urandom;
    endtask

    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.op     = SH_SLL;
        bus.offset = '0;
        bus.a      = '0;
        bus.b      = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_err", {31'b0, bus.err}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        reset = 1'b0;

        issue(SH_SLL, 16'h0100, 32'h0000_0001, 32'h0, 32'h0000_0010, 1'b0, 5, "sll4", 1'b1);
        check("sll4_busy", {31'b0, bus.busy}, 32'd1);

        issue(SH_SRAV, 16'h0000, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 32, "srav31", 1'b1);
        issue(SH_SRLV, 16'h0000, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 32, "srlv31", 1'b1);
        issue(SH_SLL, 16'h0000, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b0, 1, "sll0", 1'b1);
        issue(SH_LUI, 16'h1234, 32'hFFFF_FFFF, 32'h0, 32'h1234_0000, 1'b0, 17, "lui", 1'b1);

        issue(SH_SRL, 16'h0200, 32'hF000_0000, 32'h0, 32'h00F0_0000, 1'b0, 9, "srl8", 1'b1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = SH_SLL;
        bus.a     = 32'h1234_5678;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;

        issue(SH_SRA, 16'h0280, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 0, "sra_rst", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        check("midrst_done", {31'b0, bus.done}, 32'd0);
        check("midrst_result", bus.result, 32'd0);

        issue(SH_SRA, 16'h0280, 32'h8000_0000, 32'h0, 32'hFFE0_0000, 1'b0, 11, "sra10", 1'b1);
        issue(SH_ILLEGAL, 16'h0000, 32'h55AA_55AA, 32'h0, 32'h55AA_55AA, 1'b1, 1, "illegal", 1'b1);

        begin
            int n;
            n = 0;
            while (q.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (3) @(negedge clk);
        check("drain_pending", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
